cs: RTL and testbench

- Streaming "comparator-select" filter for the 2005 cell-based design block.
- Keeps a sliding window of the last 9 unsigned 8-bit samples X.
- Each cycle it computes the window average, then the approximate value Xappr (the largest window sample not exceeding the average).
- Output: Y = floor((sum of window + 9*Xappr)/8).

---
 rtl/cs_pkg.sv | 23 ++
 rtl/cs_appr_select.sv | 34 +++
 rtl/cs.sv | 43 ++++
 tb/tb_cs.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared types and constants for the cs comparator-select filter.
// Provides sample/sum typedefs and small arithmetic helpers.
`timescale 1ns/1ps
package cs_pkg;

  localparam int DW   = 8;
  localparam int N    = 9;
  localparam int OW   = 10;
  localparam int SUMW = 12;

  typedef logic [DW-1:0]   sample_t;
  typedef logic [SUMW-1:0] sum_t;

  // 9*v via shift-add; 9*255 = 2295 fits SUMW
  function automatic sum_t times9(sample_t v);
    return (sum_t'(v) << 3) + sum_t'(v);
  endfunction

  function automatic sample_t smax(sample_t a, sample_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cs_appr_select.sv
// Picks the largest window sample not above floor(s/9).
// Ports: w (window), s (window sum) -> xappr.
`timescale 1ns/1ps
module cs_appr_select
  import cs_pkg::*;
(
  input  sample_t w [N],
  input  sum_t    s,
  output sample_t xappr
);

  sample_t q [N];
  sample_t a0, a1, a2, a3;
  sample_t b0, b1, c0;

  // w <= floor(s/9) is equivalent to 9*w <= s
  always_comb begin
    for (int k = 0; k < N; k++) begin
      q[k] = (times9(w[k]) <= s) ? w[k] : '0;
    end
  end

  always_comb begin
    a0    = smax(q[0], q[1]);
    a1    = smax(q[2], q[3]);
    a2    = smax(q[4], q[5]);
    a3    = smax(q[6], q[7]);
    b0    = smax(a0, a1);
    b1    = smax(a2, a3);
    c0    = smax(b0, b1);
    xappr = smax(c0, q[8]);
  end

endmodule

// File: rtl/cs.sv
// Comparator-select filter: 9-sample window, Y=(S+9*Xappr)>>3.
// Ports: clk, reset (sync, high), X sample in, Y result out.
`timescale 1ns/1ps
module cs
  import cs_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] X,
  output logic [OW-1:0] Y
);

  sample_t          w [N];
  sum_t             s;
  sample_t          xappr;
  logic [SUMW:0]    acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        w[k] <= '0;
      end
      s <= '0;
    end else begin
      w[0] <= X;
      for (int k = 1; k < N; k++) begin
        w[k] <= w[k-1];
      end
      // running sum tracks the window exactly
      s <= s + sum_t'(X) - sum_t'(w[N-1]);
    end
  end

  cs_appr_select u_sel (
    .w     (w),
    .s     (s),
    .xappr (xappr)
  );

  assign acc = {1'b0, s} + {1'b0, times9(xappr)};
  assign Y   = acc[SUMW:3];

endmodule

// File: tb/tb_cs.sv
// Directed and random checks for the cs filter.
// Drives X on falling edge, checks Y 1 ns after rising edge.
`timescale 1ns/1ps
module tb_cs;

  logic       clk;
  logic       reset;
  logic [7:0] X;
  logic [9:0] Y;

  int vectors;
  int miscompares;
  int win [9];

  cs dut (
    .clk   (clk),
    .reset (reset),
    .X     (X),
    .Y     (Y)
  );

  initial clk = 1'b0;
  always #4.965 clk = ~clk;

  function automatic int model_y();
    int s, avg, appr;
    s = 0;
    for (int k = 0; k < 9; k++) s += win[k];
    avg  = s / 9;
    appr = 0;
    for (int k = 0; k < 9; k++)
      if (win[k] <= avg && win[k] > appr) appr = win[k];
    return (s + 9 * appr) >> 3;
  endfunction

  task automatic push(input logic [7:0] x);
    @(negedge clk);
    X = x;
    @(posedge clk);
    #1;
    for (int k = 8; k > 0; k--) win[k] = win[k-1];
    win[0] = x;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) win[k] = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (Y !== 10'd0) begin
      miscompares++;
      $display("FAIL reset: Y=%0d want 0", Y);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_const100();
    for (int i = 0; i < 9; i++) push(8'd100);
    vectors++;
    if (Y !== 10'd225) begin
      miscompares++;
      $display("FAIL const100: Y=%0d want 225", Y);
    end
  endtask

  task automatic test_ramp();
    for (int i = 1; i <= 9; i++) push(8'(i));
    vectors++;
    if (Y !== 10'd11) begin
      miscompares++;
      $display("FAIL ramp1_9: Y=%0d want 11", Y);
    end
    push(8'd10);
    vectors++;
    if (Y !== 10'd13) begin
      miscompares++;
      $display("FAIL ramp2_10: Y=%0d want 13", Y);
    end
  endtask

  task automatic test_avg_not_member();
    for (int i = 0; i < 8; i++) push(8'd0);
    push(8'd90);
    vectors++;
    if (Y !== 10'd11) begin
      miscompares++;
      $display("FAIL zeros_90: Y=%0d want 11", Y);
    end
  endtask

  task automatic test_max();
    for (int i = 0; i < 9; i++) push(8'd255);
    vectors++;
    if (Y !== 10'd573) begin
      miscompares++;
      $display("FAIL max255: Y=%0d want 573", Y);
    end
  endtask

  task automatic test_mid_reset();
    push(8'd37);
    push(8'd200);
    do_reset();
    vectors++;
    if (Y !== 10'd0) begin
      miscompares++;
      $display("FAIL mid_reset: Y=%0d want 0", Y);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) push(8'd8);
    vectors++;
    if (Y !== 10'd18) begin
      miscompares++;
      $display("FAIL after_reset8: Y=%0d want 18", Y);
    end
  endtask

  task automatic test_random();
    int exp_y;
    do_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      push(8'($urandom_range(0, 255)));
      if (i >= 8) begin
        exp_y = model_y();
        vectors++;
        if (Y !== 10'(exp_y)) begin
          miscompares++;
          $display("FAIL random[%0d]: Y=%0d want %0d", i, Y, exp_y);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    X           = 8'd0;
    for (int k = 0; k < 9; k++) win[k] = 0;
    test_reset();
    test_const100();
    test_ramp();
    test_avg_not_member();
    test_max();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
